// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one shared resource across 8 requesters, registered one-hot grant plus index.
// Latency 1 edge request-to-grant; the owner keeps the grant until it releases, En drops or MAX_HOLD expires.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  if (MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 0..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;
  logic       win_found;
  logic [2:0] win_idx;
  logic       hold_expire;

  // First requester at or after ptr, wrapping; ptr itself has highest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int k = 0; k < 8; k++) begin
      if (!win_found && req[ptr + 3'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr + 3'(k);
      end
    end
  end

  assign hold_expire = HOLD_EN && (hold_cnt == HOLD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= 8'h00;
      gnt_idx  <= 3'd0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 3'd0;
      hold_cnt <= 8'd0;
      state    <= IDLE;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (En && win_found) begin
            gnt      <= 8'b1 << win_idx;
            gnt_idx  <= win_idx;
            gnt_vld  <= 1'b1;
            hold_cnt <= 8'd1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Release is checked before the hold limit so a voluntary drop never pulses timeout.
          if (!En || !req[gnt_idx]) begin
            gnt     <= 8'h00;
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx + 3'd1;
            state   <= IDLE;
          end else if (hold_expire) begin
            gnt     <= 8'h00;
            gnt_vld <= 1'b0;
            timeout <= 1'b1;
            ptr     <= gnt_idx + 3'd1;
            state   <= IDLE;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_rr_arbiter8;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       En;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the resource, for how many cycles, and who is next in line.
  int         m_owner;
  int         m_held;
  int         m_ptr;
  logic [2:0] m_idx;
  logic       m_to;

  rr_arbiter8 #(.MAX_HOLD(M)) dut (
    .clk(clk), .rst(rst), .En(En), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit found;
    m_to = 1'b0;
    if (rst) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_idx = 3'd0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      if (En && req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int i;
          i = (m_ptr + k) % 8;
          if (!found && req[i]) begin
            found = 1'b1; m_owner = i; m_held = 1; m_idx = 3'(i);
          end
        end
      end
    end else if (!En || !req[m_owner]) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1;
    end else if (m_held == M) begin
      m_to = 1'b1; m_ptr = (m_owner + 1) % 8; m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  // Drive inputs (called at a falling edge), clock once, then compare all outputs at the next falling edge.
  task automatic step(input logic r, input logic e, input logic [7:0] q);
    logic [7:0] exp_gnt;
    rst = r; En = e; req = q;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    check_eq("gnt", 32'(gnt), 32'(exp_gnt));
    check_eq("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    check_eq("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
    check_eq("timeout", 32'(timeout), 32'(m_to));
  endtask

  initial begin
    int         n;
    int         len;
    logic       prev_vld;
    logic [7:0] q;
    logic [2:0] exp_seq [4];
    exp_seq = '{3'd0, 3'd2, 3'd7, 3'd0};

    // Idle with no requests.
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);

    // Rotation: owners drop after 2 cycles, then re-raise.
    step(1'b1, 1'b1, 8'h00);
    n = 0; prev_vld = 1'b0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      q = 8'h85;
      if (m_owner >= 0 && m_held == 2) q = q & ~(8'h01 << m_owner);
      step(1'b0, 1'b1, q);
      if (gnt_vld && !prev_vld) begin
        check_eq("rot_seq", 32'(gnt_idx), 32'(exp_seq[n]));
        n++;
      end
      prev_vld = gnt_vld;
    end
    check_eq("rot_count", 32'(n), 32'd4);

    // Hold limit with a sole persistent requester.
    step(1'b1, 1'b1, 8'h00);
    len = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h08);
      len += int'(gnt_vld);
    end
    check_eq("hold_len", 32'(len), 32'd4);
    step(1'b0, 1'b1, 8'h08);
    check_eq("to_pulse", 32'(timeout), 32'd1);
    step(1'b0, 1'b1, 8'h08);
    check_eq("regrant3", 32'(gnt), 32'h08);

    // Release on the same edge the limit would fire.
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h08);
    step(1'b0, 1'b1, 8'h00);
    check_eq("rel_no_to", 32'(timeout), 32'd0);

    // En drop releases and advances the pointer.
    step(1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h20);
    check_eq("en_own5", 32'(gnt_idx), 32'd5);
    step(1'b0, 1'b0, 8'h20);
    check_eq("en_drop", 32'(gnt_vld), 32'd0);
    step(1'b0, 1'b1, 8'hFF);
    check_eq("en_next6", 32'(gnt_idx), 32'd6);

    // Reset in the middle of a grant.
    step(1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'h02);
    check_eq("rst_gnt", 32'(gnt), 32'h00);
    step(1'b0, 1'b1, 8'h06);
    check_eq("rst_ptr", 32'(gnt_idx), 32'd1);

    // Randomized traffic; requests tend to persist so hold limits are exercised.
    q = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       q = 8'($urandom);
        1:       q = 8'($urandom) & 8'($urandom);
        2:       q = 8'h00;
        3:       q = q ^ (8'h01 << $urandom_range(0, 7));
        default: ;
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0, q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Accepts a request vector and issues a registered one-hot grant plus its 3-bit binary index. The index can drive the select of a downstream shared datapath directly.
- Holds each grant until the owner releases its request or a programmable hold limit expires.
- Rotating priority prevents starvation.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles one grant may be held (1..255); 0 = unlimited

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous, active-high reset
En  input  1  arbitration enable; 0 forces release and blocks new grants
req  input  8  request vector, req[i] = requester i wants the resource
gnt  output  8  registered one-hot grant; all-zero when nothing is granted
gnt_idx  output  3  binary index of the granted bit (bit position, req[0] -> 3'd0 ... req[7] -> 3'd7)
gnt_vld  output  1  1 while a grant is active (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at an edge, which overrides everything):
  - gnt=8'h00, gnt_idx=3'd0, gnt_vld=0, timeout=0.
  - Priority pointer ptr=3'd0, hold_cnt=0, state=IDLE.
  - This applies mid-grant too: the grant drops at that edge and no timeout pulse is issued.
- All outputs are registered; no combinational path from req or En to the outputs.
- State IDLE:
  - If En=1 and req!=0 at an edge: winner g = first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - At that edge: gnt=1<<g, gnt_idx=g, gnt_vld=1, hold_cnt=1, state=GRANT. Latency is 1 edge from request to grant.
  - Otherwise remain in IDLE with gnt=0. gnt_idx keeps its last value.
- State GRANT (owner g), evaluated at each edge in this priority order:
  1. En=0: gnt=0, gnt_vld=0, ptr=g+1 mod 8, state=IDLE, no timeout.
  2. req[g]=0 (owner released): same as item 1, no timeout. Release beats timeout if both occur at the same edge.
  3. MAX_HOLD!=0 and hold_cnt==MAX_HOLD: gnt=0, gnt_vld=0, timeout=1 for exactly this cycle, ptr=g+1 mod 8, state=IDLE.
  4. Otherwise: keep the grant, hold_cnt=hold_cnt+1.
- Other req bits are ignored while in GRANT; they do not preempt the owner.
- After every release or revoke there is exactly one IDLE cycle with gnt=0 before the next grant. Minimum grant-to-grant spacing is therefore 2 edges.
- Hold duration with MAX_HOLD=M and the owner holding continuously: gnt is high for exactly M cycles.
- MAX_HOLD=0: hold_cnt saturates at 255 and never triggers a timeout.
- hold_cnt is 8 bits. Synthesis must reject MAX_HOLD>255 via a parameter check.
- ptr wrap: after granting 7, ptr=0.
- A revoked requester that keeps req high is re-eligible next IDLE cycle, but at lowest priority.
- gnt is always one-hot or zero; gnt_idx always matches gnt when gnt_vld=1.

Test Plan:
- Reset, then req=8'h00, En=1 for 5 cycles -> gnt=0, gnt_vld=0, gnt_idx=0, timeout=0 throughout.
- From reset, req=8'b1000_0101 held, each owner drops req after 2 cycles then re-raises -> grant sequence idx 0, 2, 7, 0. Each grant lasts 2 cycles with a 1-cycle gap.
- MAX_HOLD=4, req=8'h08 held constantly:
  - gnt=8'h08 for exactly 4 cycles.
  - timeout=1 on the cycle gnt drops, then 1 idle cycle.
  - Regrant idx 3 follows, since it is the sole requester.
- MAX_HOLD=4, owner req drops on the same edge hold_cnt==4 -> no timeout pulse, normal release.
- Grant active to idx 5, En deasserted -> gnt=0 next edge with no timeout. Re-enable with req=8'hFF -> grant idx 6 (ptr advanced).
- Grant active to idx 1 with rst=1 for one cycle -> all outputs 0 and ptr=0. Next grant with req=8'h06 goes to idx 1.
